// File: rtl/risc16_pkg.sv
// Shared definitions for the 16-bit RISC core: opcodes, ALU selects,
// instruction field positions and the decode-to-ALU issue bundle.
package risc16_pkg;

    localparam int XLEN = 16;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_NOP  = 4'd15;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SHL = 3'b100;
    localparam logic [2:0] ALU_SHR = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      sel;
        logic [2:0]      rd;
    } issue_bundle_t;

    function automatic logic [XLEN-1:0] sext_imm6(input logic [5:0] imm);
        return {{(XLEN-6){imm[5]}}, imm};
    endfunction

    // ADDI reuses the adder; undefined opcodes never issue so their select is don't-care
    function automatic logic [2:0] alu_sel_of(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_XOR:  return ALU_XOR;
            OP_SHL:  return ALU_SHL;
            OP_SHR:  return ALU_SHR;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Fetch, issue and writeback handshakes of the decode/issue stage.
interface decode_issue_stage_if #(parameter int DW = 16);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_sel;
    logic [2:0]    alu_rd;
    logic          wb_en;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          illegal;

    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, alu_a, alu_b, alu_sel, alu_rd, illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, alu_a, alu_b, alu_sel, alu_rd, illegal
    );
endinterface

// File: rtl/regfile_8x16.sv
// Architectural register file: two asynchronous reads, one synchronous write,
// r0 hardwired to zero.
module regfile_8x16 #(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    i_raddr1,
    output logic [DW-1:0] o_rdata1,
    input  logic [2:0]    i_raddr2,
    output logic [DW-1:0] o_rdata2,
    input  logic          i_we,
    input  logic [2:0]    i_waddr,
    input  logic [DW-1:0] i_wdata
);

    logic [DW-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
        end else if (i_we && i_waddr != 3'd0) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 3'd0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 3'd0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/decode_issue_stage.sv
// Decode and operand-issue stage: decodes one instruction per cycle, reads
// operands with writeback bypass, stalls on busy registers, registers the ALU bundle.
module decode_issue_stage
    import risc16_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    decode_issue_stage_if.slave  bus
);

    logic [3:0]    w_op;
    logic [2:0]    w_rd, w_rs1, w_rs2;
    logic          w_is_r, w_is_addi, w_is_nop, w_issue, w_undef;
    logic [DW-1:0] w_rf_rd1, w_rf_rd2, w_opa, w_opb;
    logic          w_byp1, w_byp2, w_busy1, w_busy2, w_busy_rd, w_hazard, w_accept;
    logic [NREGS-1:0] w_busy_nxt;

    logic [NREGS-1:0] r_busy;
    logic             r_out_valid;
    logic             r_illegal;
    issue_bundle_t    r_bundle;

    assign w_op  = bus.in_instr[OP_HI:OP_LO];
    assign w_rd  = bus.in_instr[RD_HI:RD_LO];
    assign w_rs1 = bus.in_instr[RS1_HI:RS1_LO];
    assign w_rs2 = bus.in_instr[RS2_HI:RS2_LO];

    always_comb begin
        w_is_r    = 1'b0;
        w_is_addi = 1'b0;
        w_is_nop  = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SHL, OP_SHR, OP_OR: w_is_r = 1'b1;
            OP_ADDI: w_is_addi = 1'b1;
            OP_NOP:  w_is_nop  = 1'b1;
            default: ;
        endcase
    end

    assign w_issue = w_is_r | w_is_addi;
    assign w_undef = !w_issue && !w_is_nop;

    regfile_8x16 #(.NREGS(NREGS), .DW(DW)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raddr1 (w_rs1),
        .o_rdata1 (w_rf_rd1),
        .i_raddr2 (w_rs2),
        .o_rdata2 (w_rf_rd2),
        .i_we     (bus.wb_en),
        .i_waddr  (bus.wb_addr),
        .i_wdata  (bus.wb_data)
    );

    // A same-cycle writeback both forwards its data and lifts the RAW stall
    assign w_byp1 = bus.wb_en && (bus.wb_addr == w_rs1) && (w_rs1 != 3'd0);
    assign w_byp2 = bus.wb_en && (bus.wb_addr == w_rs2) && (w_rs2 != 3'd0);

    assign w_opa = w_byp1 ? bus.wb_data : w_rf_rd1;
    assign w_opb = w_is_addi ? sext_imm6(bus.in_instr[IMM_HI:IMM_LO])
                 : (w_byp2 ? bus.wb_data : w_rf_rd2);

    assign w_busy1   = (w_rs1 != 3'd0) && r_busy[w_rs1] && !w_byp1;
    assign w_busy2   = (w_rs2 != 3'd0) && r_busy[w_rs2] && !w_byp2;
    assign w_busy_rd = (w_rd  != 3'd0) && r_busy[w_rd];
    assign w_hazard  = w_issue && (w_busy1 || (w_is_r && w_busy2) || w_busy_rd);

    assign bus.in_ready = (!r_out_valid || bus.out_ready) && !w_hazard;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Clear first so that a set of the same bit in the same cycle wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.wb_en) w_busy_nxt[bus.wb_addr] = 1'b0;
        if (w_accept && w_issue && w_rd != 3'd0) w_busy_nxt[w_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= '0;
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_accept && w_issue) begin
                r_out_valid  <= 1'b1;
                r_bundle.a   <= w_opa;
                r_bundle.b   <= w_opb;
                r_bundle.sel <= alu_sel_of(w_op);
                r_bundle.rd  <= w_rd;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && w_undef) r_illegal <= 1'b1;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.alu_a     = r_bundle.a;
    assign bus.alu_b     = r_bundle.b;
    assign bus.alu_sel   = r_bundle.sel;
    assign bus.alu_rd    = r_bundle.rd;
    assign bus.illegal   = r_illegal;

endmodule
